control_sequencer: RTL and testbench

Microcode sequencer that drives the memory block's control inputs and consumes its latched instruction opcode. Each instruction is executed as a sequence of up to 16 steps:

- Steps 0–1 are a fixed fetch (load instruction register, increment PC) generated internally.
- Steps 2–15 come from an external asynchronous microcode ROM addressed by {opcode, step}.

The block also owns the run / halt / single-step / breakpoint state machine of the CPU.

---
 rtl/control_sequencer_if.sv | 45 ++++
 rtl/control_sequencer.sv | 168 ++++++++++++++++
 tb/tb_control_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Memory-block / microcode-ROM bus of the control sequencer.
// Timing contract (no valid/ready handshake on this bus): the sequencer drives
// o_ucodeAddress from its registered step. The ROM answers combinationally on
// i_ucodeData. The o_ctrl* levels settle within the same cycle and the memory
// block samples them on the next rising edge. i_instrCode is the opcode latched
// by the memory block at the end of fetch step 0.
interface control_sequencer_if;
  logic [7:0]  i_instrCode;
  logic [11:0] o_ucodeAddress;
  logic [31:0] i_ucodeData;
  logic        o_ctrlPCLoadN;
  logic        o_ctrlPCNEn;
  logic        o_ctrlPCFromImm;
  logic        o_ctrlMemPCToRamN;
  logic        o_ctrlSpUp;
  logic        o_ctrlSpNEn;
  logic        o_ctrlInstrNWE;
  logic        o_ctrlInstrNOE;
  logic        o_ctrlRamNOE;
  logic        o_ctrlRamNWE;
  logic        o_ctrlMemMar0NWE;
  logic        o_ctrlMemMar1NWE;
  logic        o_ctrlMemInstrImmToRamAddr;
  logic [12:0] o_ctrlAux;

  // Sequencer side
  modport master (
    input  i_instrCode, i_ucodeData,
    output o_ucodeAddress,
    output o_ctrlPCLoadN, o_ctrlPCNEn, o_ctrlPCFromImm, o_ctrlMemPCToRamN,
    output o_ctrlSpUp, o_ctrlSpNEn, o_ctrlInstrNWE, o_ctrlInstrNOE,
    output o_ctrlRamNOE, o_ctrlRamNWE, o_ctrlMemMar0NWE, o_ctrlMemMar1NWE,
    output o_ctrlMemInstrImmToRamAddr, o_ctrlAux
  );

  // Memory block / ROM side
  modport slave (
    output i_instrCode, i_ucodeData,
    input  o_ucodeAddress,
    input  o_ctrlPCLoadN, o_ctrlPCNEn, o_ctrlPCFromImm, o_ctrlMemPCToRamN,
    input  o_ctrlSpUp, o_ctrlSpNEn, o_ctrlInstrNWE, o_ctrlInstrNOE,
    input  o_ctrlRamNOE, o_ctrlRamNWE, o_ctrlMemMar0NWE, o_ctrlMemMar1NWE,
    input  o_ctrlMemInstrImmToRamAddr, o_ctrlAux
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcode sequencer: fixed two-step fetch, then ROM-driven steps 2..15,
// plus the CPU run / halt / single-step / breakpoint state machine.
module control_sequencer #(
  parameter int RESET_CYCLES = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  control_sequencer_if.master bus,
  input  logic [3:0]          i_flags,
  input  logic                i_runMode,
  input  logic                i_stepReq,
  input  logic                i_breakpointHit,
  output logic [3:0]          o_step,
  output logic [1:0]          o_state,
  output logic                o_halted
);

  localparam logic [1:0] S_RESET_HOLD = 2'd0;
  localparam logic [1:0] S_RUN        = 2'd1;
  localparam logic [1:0] S_STEP       = 2'd2;
  localparam logic [1:0] S_HALTED     = 2'd3;

  localparam int                HOLD_W      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(RESET_CYCLES - 1);

  // Control bits in port order: [0] PCLoadN .. [12] MemInstrImmToRamAddr.
  // Active-low controls idle at 1, the rest at 0.
  localparam logic [12:0] CTRL_INACTIVE = 13'h0FEB;
  localparam int          B_PC_N_EN     = 1;
  localparam int          B_INSTR_NWE   = 6;

  logic [1:0]        state_q, state_d;
  logic [3:0]        step_q, step_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              bp_skip_q, bp_skip_d;
  logic              run_prev_q, run_prev_d;
  logic              step_req_prev_q, step_req_prev_d;

  logic [31:0] uword;
  logic [12:0] ctrl;
  logic [12:0] aux;
  logic        active;
  logic        bp_stop;
  logic        cond;
  logic        cond_fail;
  logic        instr_end;
  logic        instr_halt;
  logic        run_rise;
  logic        step_rise;

  assign uword     = bus.i_ucodeData;
  assign active    = (state_q == S_RUN) || (state_q == S_STEP);
  // Breakpoint only stops a free run, only at an instruction boundary, and not
  // on the first instruction after a resume.
  assign bp_stop   = (state_q == S_RUN) && (step_q == 4'd0) && i_breakpointHit && !bp_skip_q;
  assign cond      = i_flags[uword[17:16]] ^ uword[18];
  assign cond_fail = uword[15] && !cond;
  assign run_rise  = i_runMode && !run_prev_q;
  assign step_rise = i_stepReq && !step_req_prev_q;

  // Select the control word for this step and detect the last step of an instruction.
  always_comb begin
    ctrl       = CTRL_INACTIVE;
    aux        = '0;
    instr_end  = 1'b0;
    instr_halt = 1'b0;
    if (active && !bp_stop) begin
      case (step_q)
        4'd0: ctrl[B_INSTR_NWE] = 1'b0;
        4'd1: ctrl[B_PC_N_EN]   = 1'b0;
        default: begin
          if (cond_fail) begin
            // Failed condition: suppress the word and terminate the instruction.
            instr_end = 1'b1;
          end else begin
            ctrl       = uword[12:0];
            aux        = uword[31:19];
            instr_halt = uword[14];
            instr_end  = uword[13] | uword[14] | (step_q == 4'd15);
          end
        end
      endcase
    end
  end

  // Next state, step counter, reset-hold counter, breakpoint skip and edge history.
  always_comb begin
    state_d         = state_q;
    step_d          = step_q;
    hold_d          = hold_q;
    bp_skip_d       = bp_skip_q;
    run_prev_d      = i_runMode;
    step_req_prev_d = i_stepReq;
    case (state_q)
      S_RESET_HOLD: begin
        step_d = 4'd0;
        if (hold_q == '0) begin
          state_d = i_runMode ? S_RUN : S_HALTED;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      S_RUN, S_STEP: begin
        if (bp_stop) begin
          state_d = S_HALTED;
          step_d  = 4'd0;
        end else if (instr_end) begin
          step_d    = 4'd0;
          bp_skip_d = 1'b0;
          if ((state_q == S_STEP) || instr_halt || !i_runMode) begin
            state_d = S_HALTED;
          end
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      default: begin
        step_d = 4'd0;
        if (run_rise) begin
          state_d   = S_RUN;
          bp_skip_d = 1'b1;
        end else if (step_rise) begin
          state_d = S_STEP;
        end
      end
    endcase
  end

  // State registers; reset forces the inactive word through RESET_HOLD immediately.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q         <= S_RESET_HOLD;
      step_q          <= 4'd0;
      hold_q          <= HOLD_RELOAD;
      bp_skip_q       <= 1'b0;
      run_prev_q      <= 1'b1;
      step_req_prev_q <= 1'b1;
    end else begin
      state_q         <= state_d;
      step_q          <= step_d;
      hold_q          <= hold_d;
      bp_skip_q       <= bp_skip_d;
      run_prev_q      <= run_prev_d;
      step_req_prev_q <= step_req_prev_d;
    end
  end

  assign bus.o_ucodeAddress             = {bus.i_instrCode, step_q};
  assign bus.o_ctrlPCLoadN              = ctrl[0];
  assign bus.o_ctrlPCNEn                = ctrl[1];
  assign bus.o_ctrlPCFromImm            = ctrl[2];
  assign bus.o_ctrlMemPCToRamN          = ctrl[3];
  assign bus.o_ctrlSpUp                 = ctrl[4];
  assign bus.o_ctrlSpNEn                = ctrl[5];
  assign bus.o_ctrlInstrNWE             = ctrl[6];
  assign bus.o_ctrlInstrNOE             = ctrl[7];
  assign bus.o_ctrlRamNOE               = ctrl[8];
  assign bus.o_ctrlRamNWE               = ctrl[9];
  assign bus.o_ctrlMemMar0NWE           = ctrl[10];
  assign bus.o_ctrlMemMar1NWE           = ctrl[11];
  assign bus.o_ctrlMemInstrImmToRamAddr = ctrl[12];
  assign bus.o_ctrlAux                  = aux;

  assign o_step   = step_q;
  assign o_state  = state_q;
  assign o_halted = (state_q == S_HALTED);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios followed by randomized
// traffic, all compared against an instruction-level reference model.
module tb_control_sequencer;

  localparam int          RESET_CYCLES = 4;
  localparam logic [12:0] INACTIVE     = 13'h0FEB;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [3:0] i_flags;
  logic       i_runMode;
  logic       i_stepReq;
  logic       i_breakpointHit;
  logic [3:0] o_step;
  logic [1:0] o_state;
  logic       o_halted;

  control_sequencer_if bus();

  logic [31:0] rom [0:4095];
  assign bus.i_ucodeData = rom[bus.o_ucodeAddress];

  control_sequencer #(.RESET_CYCLES(RESET_CYCLES)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .bus            (bus),
    .i_flags        (i_flags),
    .i_runMode      (i_runMode),
    .i_stepReq      (i_stepReq),
    .i_breakpointHit(i_breakpointHit),
    .o_step         (o_step),
    .o_state        (o_state),
    .o_halted       (o_halted)
  );

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes use the o_state numbering: 0 reset hold, 1 run, 2 step, 3 halted.
  int          m_state;
  int          m_idx;
  int          m_hold;
  bit          m_skip;
  bit          m_prev_run;
  bit          m_prev_step;
  bit          m_bp_now;
  bit          m_halt_instr;
  logic [25:0] exp_q[$];   // {aux, ctrl} for each remaining step of the instruction

  task automatic model_reset();
    m_state      = 0;
    m_idx        = 0;
    m_hold       = RESET_CYCLES;
    m_skip       = 1'b0;
    m_prev_run   = 1'b1;
    m_prev_step  = 1'b1;
    m_bp_now     = 1'b0;
    m_halt_instr = 1'b0;
    exp_q.delete();
  endtask

  // Expand a whole instruction into its list of expected control words.
  task automatic build_instr(input logic [7:0] op, input logic [3:0] fl);
    logic [31:0] w;
    logic        cond;
    exp_q.delete();
    m_halt_instr = 1'b0;
    exp_q.push_back({13'd0, INACTIVE & ~13'h040});
    exp_q.push_back({13'd0, INACTIVE & ~13'h002});
    for (int s = 2; s < 16; s++) begin
      w    = rom[{op, 4'(s)}];
      cond = fl[w[17:16]] ^ w[18];
      if (w[15] && !cond) begin
        exp_q.push_back({13'd0, INACTIVE});
        break;
      end
      exp_q.push_back({w[31:19], w[12:0]});
      if (w[14]) m_halt_instr = 1'b1;
      if (w[13] || w[14]) break;
    end
  endtask

  function automatic logic [12:0] dut_ctrl();
    return {bus.o_ctrlMemInstrImmToRamAddr, bus.o_ctrlMemMar1NWE, bus.o_ctrlMemMar0NWE,
            bus.o_ctrlRamNWE, bus.o_ctrlRamNOE, bus.o_ctrlInstrNOE, bus.o_ctrlInstrNWE,
            bus.o_ctrlSpNEn, bus.o_ctrlSpUp, bus.o_ctrlMemPCToRamN, bus.o_ctrlPCFromImm,
            bus.o_ctrlPCNEn, bus.o_ctrlPCLoadN};
  endfunction

  task automatic check_cycle();
    logic [25:0] e;
    int          es;
    e  = {13'd0, INACTIVE};
    es = 0;
    if (!i_reset && (m_state == 1 || m_state == 2)) begin
      if (exp_q.size() == 0) begin
        if (m_state == 1 && i_breakpointHit && !m_skip) m_bp_now = 1'b1;
        else build_instr(bus.i_instrCode, i_flags);
      end
      if (!m_bp_now) begin
        e  = exp_q[0];
        es = m_idx;
      end
    end
    check_val("state",  32'(o_state), 32'(m_state));
    check_val("step",   32'(o_step), 32'(es));
    check_val("halted", 32'(o_halted), (m_state == 3) ? 32'd1 : 32'd0);
    check_val("addr",   32'(bus.o_ucodeAddress), 32'({bus.i_instrCode, 4'(es)}));
    check_val("ctrl",   32'(dut_ctrl()), 32'(e[12:0]));
    check_val("aux",    32'(bus.o_ctrlAux), 32'(e[25:13]));
  endtask

  task automatic model_advance();
    if (i_reset) begin
      model_reset();
      return;
    end
    case (m_state)
      0: begin
        m_hold--;
        if (m_hold == 0) m_state = i_runMode ? 1 : 3;
      end
      1, 2: begin
        if (m_bp_now) begin
          m_bp_now = 1'b0;
          m_state  = 3;
        end else begin
          exp_q.delete(0);
          m_idx++;
          if (exp_q.size() == 0) begin
            m_idx  = 0;
            m_skip = 1'b0;
            if (m_state == 2 || m_halt_instr || !i_runMode) m_state = 3;
          end
        end
      end
      default: begin
        if (i_runMode && !m_prev_run) begin
          m_state = 1;
          m_skip  = 1'b1;
        end else if (i_stepReq && !m_prev_step) begin
          m_state = 2;
        end
      end
    endcase
    m_prev_run  = i_runMode;
    m_prev_step = i_stepReq;
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are changed just after a rising edge; checks happen on the falling edge.
  task automatic cycle();
    @(negedge i_clk);
    check_cycle();
    @(posedge i_clk);
    model_advance();
    #1;
  endtask

  task automatic pulse_step();
    i_stepReq = 1'b1;
    cycle();
    i_stepReq = 1'b0;
  endtask

  task automatic toggle_run();
    i_runMode = 1'b0;
    cycle();
    i_runMode = 1'b1;
    cycle();
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w     = $urandom;
    w[13] = ($urandom_range(0, 3) == 0);
    w[14] = ($urandom_range(0, 15) == 0);
    w[15] = ($urandom_range(0, 2) == 0);
    if (w[15]) w[14] = 1'b0;
    return w;
  endfunction

  task automatic fill_rom();
    for (int a = 0; a < 4096; a++) rom[a] = rand_word();
    rom[12'h122] = {13'd5, 6'b000000, INACTIVE & ~13'h100};
    rom[12'h123] = {13'd0, 6'b000001, INACTIVE & ~13'h100};
    rom[12'h342] = {13'd3, 6'b001100, INACTIVE & ~13'h200};
    rom[12'h343] = {13'd0, 6'b000001, INACTIVE & ~13'h400};
    rom[12'h562] = {13'd0, 6'b000010, INACTIVE | 13'h010};
    for (int s = 2; s < 16; s++) rom[{8'h78, 4'(s)}] = {13'(s), 6'b000000, INACTIVE & ~13'h100};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_reset         = 1'b1;
    i_runMode       = 1'b1;
    i_stepReq       = 1'b0;
    i_breakpointHit = 1'b0;
    i_flags         = 4'd0;
    bus.i_instrCode = 8'h12;
    fill_rom();
    model_reset();
    cycle();
    cycle();
    i_reset = 1'b0;

    // Reset hold, then the normal 0x12 instruction; runMode dropped so it halts after.
    for (int i = 0; i < RESET_CYCLES; i++) begin
      check_val("hold_state", 32'(o_state), 32'd0);
      check_val("hold_nwe", 32'(bus.o_ctrlInstrNWE), 32'd1);
      cycle();
    end
    check_val("run_state", 32'(o_state), 32'd1);
    check_val("fetch_nwe", 32'(bus.o_ctrlInstrNWE), 32'd0);
    check_val("fetch_addr", 32'(bus.o_ucodeAddress), 32'h120);
    i_runMode = 1'b0;
    cycle();
    check_val("inc_pcnen", 32'(bus.o_ctrlPCNEn), 32'd0);
    check_val("inc_addr", 32'(bus.o_ucodeAddress), 32'h121);
    cycle();
    check_val("s2_ramnoe", 32'(bus.o_ctrlRamNOE), 32'd0);
    check_val("s2_aux", 32'(bus.o_ctrlAux), 32'd5);
    check_val("s2_addr", 32'(bus.o_ucodeAddress), 32'h122);
    cycle();
    check_val("s3_ramnoe", 32'(bus.o_ctrlRamNOE), 32'd0);
    check_val("s3_addr", 32'(bus.o_ucodeAddress), 32'h123);
    cycle();
    check_val("rundrop_halt", 32'(o_state), 32'd3);

    // Conditional step on Z: first failing, then passing.
    bus.i_instrCode = 8'h34;
    i_flags = 4'b0000;
    pulse_step();
    cycle();
    cycle();
    check_val("cond_fail_ctrl", 32'(dut_ctrl()), 32'(INACTIVE));
    cycle();
    check_val("cond_fail_end", 32'(o_state), 32'd3);
    i_flags = 4'b0010;
    pulse_step();
    cycle();
    cycle();
    check_val("cond_pass_nwe", 32'(bus.o_ctrlRamNWE), 32'd0);
    check_val("cond_pass_aux", 32'(bus.o_ctrlAux), 32'd3);
    cycle();
    check_val("cond_pass_step", 32'(o_step), 32'd3);
    cycle();
    check_val("cond_pass_halt", 32'(o_state), 32'd3);

    // Step request held high: exactly one instruction.
    bus.i_instrCode = 8'h12;
    i_stepReq = 1'b1;
    repeat (12) cycle();
    check_val("step_held", 32'(o_state), 32'd3);
    i_stepReq = 1'b0;
    cycle();

    // Halt-bit instruction in RUN.
    bus.i_instrCode = 8'h56;
    i_runMode = 1'b1;
    cycle();
    repeat (3) cycle();
    check_val("halt_bit", 32'(o_state), 32'd3);

    // Breakpoint: stop at a boundary, then resume past a still-active hit.
    bus.i_instrCode = 8'h12;
    toggle_run();
    repeat (4) cycle();
    i_breakpointHit = 1'b1;
    #1;
    check_val("bp_no_fetch", 32'(bus.o_ctrlInstrNWE), 32'd1);
    cycle();
    check_val("bp_halted", 32'(o_state), 32'd3);
    toggle_run();
    check_val("bp_skip_fetch", 32'(bus.o_ctrlInstrNWE), 32'd0);
    repeat (4) cycle();
    check_val("bp_again_nwe", 32'(bus.o_ctrlInstrNWE), 32'd1);
    cycle();
    check_val("bp_again_halt", 32'(o_state), 32'd3);
    i_breakpointHit = 1'b0;

    // Full 16-step instruction, then asynchronous reset mid-instruction.
    bus.i_instrCode = 8'h78;
    pulse_step();
    repeat (15) cycle();
    check_val("len16_step", 32'(o_step), 32'd15);
    cycle();
    check_val("len16_halt", 32'(o_state), 32'd3);
    toggle_run();
    repeat (5) cycle();
    check_val("pre_reset_step", 32'(o_step), 32'd5);
    i_reset = 1'b1;
    model_reset();
    #1;
    check_val("areset_step", 32'(o_step), 32'd0);
    check_val("areset_state", 32'(o_state), 32'd0);
    check_val("areset_ctrl", 32'(dut_ctrl()), 32'(INACTIVE));
    check_val("areset_aux", 32'(bus.o_ctrlAux), 32'd0);
    cycle();
    i_reset = 1'b0;

    // Randomized traffic over the random part of the ROM.
    for (int c = 0; c < 3000; c++) begin
      if (exp_q.size() == 0) begin
        bus.i_instrCode = 8'($urandom_range(128, 255));
        i_flags = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 39) == 0) i_runMode = ~i_runMode;
      i_stepReq       = ($urandom_range(0, 5) == 0);
      i_breakpointHit = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 599) == 0) begin
        i_reset = 1'b1;
        model_reset();
      end else begin
        i_reset = 1'b0;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
